// File: rtl/util_wdt_pkg.sv
// util_wdt_pkg: shared definitions for the heartbeat watchdog supervisor.
//   STATE_W / RETRY_W : widths of the status fields exposed to the CSR block
//   wdt_state_e       : supervisor state encoding (mirrored on o_fsm_state)
package util_wdt_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned PRESET_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_RUN     = 3'd2,
    ST_RECOVER = 3'd3,
    ST_FAULT   = 3'd4
  } wdt_state_e;

endpackage

// File: rtl/util_tick_gen.sv
// util_tick_gen: free-running prescaler producing a one-cycle tick every PRESCALE clocks.
//   clk, rstn  : clock, synchronous active-low reset
//   i_en       : count enable; low clears the prescaler
//   i_clr      : synchronous clear, dominates i_en
//   o_tick_c   : high on the cycle the prescaler holds PRESCALE-1 (combinational from the count)
module util_tick_gen #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_active;

  assign w_active = i_en & ~i_clr;

  // Prescaler: 0..PRESCALE-1, wrap on the tick cycle
  always_ff @(posedge clk) begin
    if (!rstn || !w_active) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick_c = w_active && (r_cnt == LAST);

endmodule

// File: rtl/util_wdt_supervisor.sv
// util_wdt_supervisor: heartbeat watchdog with automatic target reset and bounded retries.
//   clk, rstn         : clock, synchronous active-low reset
//   i_en              : supervisor enable; low forces IDLE and clears all status
//   i_preset[31:0]    : timeout in ticks, sampled on every counter load
//   i_heartbeat       : single-cycle alive pulse from the target
//   i_ack_fault       : single-cycle software acknowledge of a latched fault
//   o_target_rst      : active-high reset request to the target
//   o_timeout_pulse   : one-cycle strobe per detected expiry
//   o_fault           : high while in FAULT
//   o_fsm_state[2:0]  : current state encoding
//   o_retry_cnt[3:0]  : recoveries since the last good heartbeat
module util_wdt_supervisor
  import util_wdt_pkg::*;
#(
  parameter int unsigned PRESCALE  = 100,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned RST_LEN   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_en,
  input  logic [PRESET_W-1:0] i_preset,
  input  logic                i_heartbeat,
  input  logic                i_ack_fault,
  output logic                o_target_rst,
  output logic                o_timeout_pulse,
  output logic                o_fault,
  output logic [STATE_W-1:0]  o_fsm_state,
  output logic [RETRY_W-1:0]  o_retry_cnt
);

  // Pulse counter holds cycles remaining after the current one, so it only needs RST_LEN-1
  localparam int unsigned RST_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_LEN - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  wdt_state_e          r_state;
  logic [PRESET_W-1:0] r_cnt;
  logic [RST_W-1:0]    r_rst_cnt;
  logic [RETRY_W-1:0]  r_retry;
  logic                r_target_rst;
  logic                r_timeout_pulse;
  logic                r_fault;

  logic                w_tick_en;
  logic                w_tick;

  // Prescaler only runs while timing (ARM/RUN); it restarts from 0 on every re-arm
  assign w_tick_en = i_en && ((r_state == ST_ARM) || (r_state == ST_RUN));

  util_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk      (clk),
    .rstn     (rstn),
    .i_en     (w_tick_en),
    .i_clr    (~w_tick_en),
    .o_tick_c (w_tick)
  );

  // Supervisor FSM, timeout down-counter and recovery pulse counter
  always_ff @(posedge clk) begin
    if (!rstn || !i_en) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_rst_cnt       <= '0;
      r_retry         <= '0;
      r_target_rst    <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_fault         <= 1'b0;
    end else begin
      r_timeout_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_ARM;
        end
        ST_ARM: begin
          if (i_heartbeat) begin
            r_state <= ST_RUN;
            r_cnt   <= i_preset;
          end
        end
        ST_RUN: begin
          // Heartbeat wins over a same-cycle tick
          if (i_heartbeat) begin
            r_cnt   <= i_preset;
            r_retry <= '0;
          end else if (w_tick) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - PRESET_W'(1);
            end else begin
              r_timeout_pulse <= 1'b1;
              r_target_rst    <= 1'b1;
              if (r_retry < RETRY_LIM) begin
                r_state   <= ST_RECOVER;
                r_retry   <= r_retry + RETRY_W'(1);
                r_rst_cnt <= RST_LAST;
              end else begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
              end
            end
          end
        end
        ST_RECOVER: begin
          if (r_rst_cnt == '0) begin
            r_state      <= ST_ARM;
            r_target_rst <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt - RST_W'(1);
          end
        end
        ST_FAULT: begin
          if (i_ack_fault) begin
            r_state      <= ST_ARM;
            r_fault      <= 1'b0;
            r_target_rst <= 1'b0;
            r_retry      <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_target_rst    = r_target_rst;
  assign o_timeout_pulse = r_timeout_pulse;
  assign o_fault         = r_fault;
  assign o_fsm_state     = r_state;
  assign o_retry_cnt     = r_retry;

endmodule

// File: tb/tb_util_wdt_supervisor.sv
// tb_util_wdt_supervisor: directed scenarios plus randomized traffic against a behavioural model.
module tb_util_wdt_supervisor;

  localparam int PRESCALE  = 4;
  localparam int RETRY_MAX = 2;
  localparam int RST_LEN   = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [31:0] preset;
  logic        hb;
  logic        ack;
  logic        target_rst;
  logic        timeout_pulse;
  logic        fault;
  logic [2:0]  fsm_state;
  logic [3:0]  retry_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: states as plain ints (0 idle,1 arm,2 run,3 recover,4 fault)
  int     m_state, m_phase, m_retry, m_rec;
  longint m_load, m_ticks;
  bit     m_trst, m_tpulse, m_fault;

  util_wdt_supervisor #(
    .PRESCALE  (PRESCALE),
    .RETRY_MAX (RETRY_MAX),
    .RST_LEN   (RST_LEN)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .i_en            (en),
    .i_preset        (preset),
    .i_heartbeat     (hb),
    .i_ack_fault     (ack),
    .o_target_rst    (target_rst),
    .o_timeout_pulse (timeout_pulse),
    .o_fault         (fault),
    .o_fsm_state     (fsm_state),
    .o_retry_cnt     (retry_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic model_clear();
    m_state = 0; m_phase = 0; m_retry = 0; m_rec = 0;
    m_load = 0; m_ticks = 0; m_trst = 0; m_tpulse = 0; m_fault = 0;
  endtask

  // Advance the model by one clock edge using the inputs the DUT sees at that edge
  task automatic model_step();
    bit timing;
    bit tick;
    timing = (m_state == 1) || (m_state == 2);
    tick   = timing && (m_phase == PRESCALE - 1);
    if (!rstn || !en) begin
      model_clear();
    end else begin
      m_phase  = timing ? (m_phase + 1) % PRESCALE : 0;
      m_tpulse = 0;
      case (m_state)
        0: m_state = 1;
        1: if (hb) begin m_state = 2; m_load = longint'(preset); m_ticks = 0; end
        2: begin
          if (hb) begin
            m_load = longint'(preset); m_ticks = 0; m_retry = 0;
          end else if (tick) begin
            if (m_ticks == m_load) begin
              m_tpulse = 1; m_trst = 1;
              if (m_retry < RETRY_MAX) begin
                m_state = 3; m_retry++; m_rec = 1;
              end else begin
                m_state = 4; m_fault = 1;
              end
            end else begin
              m_ticks++;
            end
          end
        end
        3: if (m_rec == RST_LEN) begin m_state = 1; m_trst = 0; end else m_rec++;
        4: if (ack) begin m_state = 1; m_fault = 0; m_trst = 0; m_retry = 0; end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_hb();
    hb = 1'b1;
    cycle();
    hb = 1'b0;
  endtask

  // Stimulus helper: heartbeat, then silence until a timeout strobe (n=0 if none)
  task automatic hb_then_expire(output int n);
    pulse_hb();
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      cycle();
      if (timeout_pulse === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_state(input int s, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (fsm_state === 3'(s)) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    bit bad;
    rstn = 1'b0; en = 1'b1; hb = 1'b0; ack = 1'b0; preset = 32'd3;
    repeat (3) cycle();
    n_cmp++;
    if ({target_rst, timeout_pulse, fault, fsm_state, retry_cnt} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got trst=%b tp=%b flt=%b st=%0d rc=%0d, want all 0",
               target_rst, timeout_pulse, fault, fsm_state, retry_cnt);
    end
    rstn = 1'b1;
    cycle();
    n_cmp++;
    if (fsm_state !== 3'd1) begin
      n_err++;
      $display("FAIL reset_release_arm: got state %0d, want 1", fsm_state);
    end
    bad = 1'b0;
    repeat (1000) begin
      cycle();
      if (timeout_pulse !== 1'b0 || fsm_state !== 3'd1 || target_rst !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL arm_no_timeout: got activity in ARM without heartbeat, want none");
    end
  endtask

  task automatic test_keepalive();
    bit bad;
    preset = 32'd3;
    pulse_hb();
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      repeat (9) begin
        cycle();
        if (timeout_pulse !== 1'b0 || retry_cnt !== 4'd0 || fsm_state !== 3'd2) bad = 1'b1;
      end
      pulse_hb();
      if (timeout_pulse !== 1'b0 || retry_cnt !== 4'd0 || fsm_state !== 3'd2) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL keepalive: got timeout/retry/state change, want steady RUN retry 0");
    end
  endtask

  task automatic test_single_expiry();
    int n, hi, tp;
    preset = 32'd3;
    hb_then_expire(n);
    n_cmp++;
    if (n < 13 || n > 16) begin
      n_err++;
      $display("FAIL expiry_latency: got %0d cycles, want 13..16", n);
    end
    n_cmp++;
    if (fsm_state !== 3'd3 || target_rst !== 1'b1) begin
      n_err++;
      $display("FAIL expiry_recover: got state %0d trst %b, want 3/1", fsm_state, target_rst);
    end
    hi = 1; tp = 1;
    while (hi < 20) begin
      cycle();
      if (timeout_pulse === 1'b1) tp++;
      if (target_rst !== 1'b1) break;
      hi++;
    end
    n_cmp++;
    if (hi !== RST_LEN || tp !== 1) begin
      n_err++;
      $display("FAIL rst_pulse: got trst %0d cycles, %0d strobes, want %0d / 1", hi, tp, RST_LEN);
    end
    n_cmp++;
    if (fsm_state !== 3'd1 || retry_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL recover_rearm: got state %0d retry %0d, want 1/1", fsm_state, retry_cnt);
    end
  endtask

  task automatic test_fault();
    int n;
    bit ok, bad;
    hb_then_expire(n);
    n_cmp++;
    if (n == 0 || fsm_state !== 3'd3 || retry_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL second_expiry: got n=%0d state %0d retry %0d, want >0/3/2", n, fsm_state, retry_cnt);
    end
    wait_state(1, ok);
    hb_then_expire(n);
    n_cmp++;
    if (n == 0 || fsm_state !== 3'd4 || fault !== 1'b1 || target_rst !== 1'b1 || retry_cnt !== 4'd2) begin
      n_err++;
      $display("FAIL third_expiry_fault: got n=%0d st %0d flt %b trst %b rc %0d, want >0/4/1/1/2",
               n, fsm_state, fault, target_rst, retry_cnt);
    end
    bad = 1'b0;
    repeat (10) begin
      pulse_hb();
      if (fsm_state !== 3'd4 || fault !== 1'b1 || target_rst !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL fault_hold: got FAULT released without ack, want held");
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    n_cmp++;
    if (fsm_state !== 3'd1 || fault !== 1'b0 || retry_cnt !== 4'd0 || target_rst !== 1'b0) begin
      n_err++;
      $display("FAIL fault_ack: got st %0d flt %b rc %0d trst %b, want 1/0/0/0",
               fsm_state, fault, retry_cnt, target_rst);
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    n_cmp++;
    if (fsm_state !== 3'd1) begin
      n_err++;
      $display("FAIL ack_outside_fault: got state %0d, want 1", fsm_state);
    end
  endtask

  task automatic test_hb_on_tick();
    int n;
    preset = 32'd0;
    pulse_hb();
    // Line a heartbeat up with the tick that would expire the counter
    for (int k = 0; k < PRESCALE && m_phase != PRESCALE - 1; k++) cycle();
    pulse_hb();
    n_cmp++;
    if (timeout_pulse !== 1'b0 || fsm_state !== 3'd2) begin
      n_err++;
      $display("FAIL hb_wins_tick: got tp %b state %0d, want 0/2", timeout_pulse, fsm_state);
    end
    n = 0;
    for (int k = 1; k <= 2 * PRESCALE; k++) begin
      cycle();
      if (timeout_pulse === 1'b1) begin
        n = k;
        break;
      end
    end
    n_cmp++;
    if (n !== PRESCALE) begin
      n_err++;
      $display("FAIL preset0_first_tick: got expiry after %0d cycles, want %0d", n, PRESCALE);
    end
  endtask

  task automatic test_en_and_reset();
    int n;
    bit ok;
    cycle();
    en = 1'b0;
    cycle();
    en = 1'b1;
    n_cmp++;
    if ({target_rst, timeout_pulse, fault, fsm_state, retry_cnt} !== 10'd0) begin
      n_err++;
      $display("FAIL en_drop_recover: got trst %b flt %b st %0d rc %0d, want all 0",
               target_rst, fault, fsm_state, retry_cnt);
    end
    cycle();
    n_cmp++;
    if (fsm_state !== 3'd1) begin
      n_err++;
      $display("FAIL en_restore_arm: got state %0d, want 1", fsm_state);
    end
    preset = 32'd0;
    for (int e = 0; e <= RETRY_MAX; e++) begin
      wait_state(1, ok);
      hb_then_expire(n);
    end
    n_cmp++;
    if (fsm_state !== 3'd4 || fault !== 1'b1) begin
      n_err++;
      $display("FAIL reach_fault: got state %0d fault %b, want 4/1", fsm_state, fault);
    end
    cycle();
    en = 1'b0;
    cycle();
    en = 1'b1;
    n_cmp++;
    if ({target_rst, timeout_pulse, fault, fsm_state, retry_cnt} !== 10'd0) begin
      n_err++;
      $display("FAIL en_drop_fault: got trst %b flt %b st %0d rc %0d, want all 0",
               target_rst, fault, fsm_state, retry_cnt);
    end
    cycle();
    preset = 32'd5;
    pulse_hb();
    cycle();
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    n_cmp++;
    if ({target_rst, timeout_pulse, fault, fsm_state, retry_cnt} !== 10'd0) begin
      n_err++;
      $display("FAIL rstn_mid_run: got trst %b flt %b st %0d rc %0d, want all 0",
               target_rst, fault, fsm_state, retry_cnt);
    end
  endtask

  task automatic test_random();
    logic [9:0] exp_v, act_v;
    int hb_div;
    rstn = 1'b0; en = 1'b1; hb = 1'b0; ack = 1'b0;
    cycle();
    rstn = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) hb_div = (c / 400) % 3 == 0 ? 3 : ((c / 400) % 3 == 1 ? 12 : 40);
      hb     = ($urandom_range(hb_div - 1) == 0);
      ack    = ($urandom_range(19) == 0);
      en     = ($urandom_range(299) != 0);
      rstn   = ($urandom_range(499) != 0);
      preset = 32'($urandom_range(6));
      cycle();
      exp_v = {3'(m_state), m_trst, m_tpulse, m_fault, 4'(m_retry)};
      act_v = {fsm_state, target_rst, timeout_pulse, fault, retry_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL random_cycle_%0d: got st/trst/tp/flt/rc %0d/%b/%b/%b/%0d, want %0d/%b/%b/%b/%0d",
                 c, fsm_state, target_rst, timeout_pulse, fault, retry_cnt,
                 m_state, m_trst, m_tpulse, m_fault, m_retry);
      end
    end
    hb = 1'b0; ack = 1'b0; en = 1'b1; rstn = 1'b1;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_keepalive();
    test_single_expiry();
    test_fault();
    test_hb_on_tick();
    test_en_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
